// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: light encodings, pedestrian FSM states
// and the width of the served-walk counter.
package traffic_pkg;

    typedef enum logic [2:0] {
        Red    = 3'd0,
        Green  = 3'd1,
        Yellow = 3'd2,
        On     = 3'd3,
        Off    = 3'd4
    } light_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } ped_state_t;

    localparam int SERVED_W = 8;
    localparam logic [SERVED_W-1:0] SERVED_MAX = '1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer; rise is a
// registered single-cycle pulse on each accepted low-to-high transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic sys_clkp,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_reg;
    logic        db_reg;
    logic        db_dly_reg;
    logic        rise_reg;
    logic [15:0] cnt_reg;

    always_ff @(posedge sys_clkp) begin
        if (reset) begin
            sync_reg   <= '0;
            db_reg     <= 1'b0;
            db_dly_reg <= 1'b0;
            rise_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            // Any sample that agrees with the accepted level restarts the run.
            if (sync_reg[1] != db_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    db_reg  <= sync_reg[1];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end else begin
                cnt_reg <= '0;
            end
            db_dly_reg <= db_reg;
            rise_reg   <= db_reg & ~db_dly_reg;
        end
    end

    assign dout = db_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request front-end: debounced button -> request FSM -> ped_req/wait_led.
// Define PED_REQUEST_BLINK_EN to make wait_led blink while a request is pending.
module ped_request
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int BLINK_HALF      = 8
) (
    input  logic                sys_clkp,
    input  logic                reset,
    input  logic                button,
    input  logic                walk_on,
    output logic                ped_req,
    output logic                wait_led,
    output logic [SERVED_W-1:0] served_cnt,
    output logic [1:0]          state_o
);

    localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 65535) begin : g_bad_cooldown
        $error("COOLDOWN_CYCLES out of range");
    end
    if (BLINK_HALF < 1 || BLINK_HALF > 65535) begin : g_bad_blink
        $error("BLINK_HALF out of range");
    end

    logic btn_db;
    logic btn_rise;
    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .sys_clkp(sys_clkp),
        .reset   (reset),
        .din     (button),
        .dout    (btn_db),
        .rise    (btn_rise)
    );

    // The debounced level cannot fall within a rise pulse; qualifying keeps the intent explicit.
    assign press = btn_rise & btn_db;

    ped_state_t          state_reg, state_next;
    logic [15:0]         cool_cnt_reg, cool_cnt_next;
    logic [SERVED_W-1:0] served_reg, served_next;
    logic                ped_req_reg;
    logic                walk_q_reg;
    logic                walk_rise;
    logic                walk_fall;

    assign walk_rise = walk_on & ~walk_q_reg;
    assign walk_fall = ~walk_on & walk_q_reg;

    always_ff @(posedge sys_clkp) begin
        if (reset) begin
            state_reg    <= IDLE;
            cool_cnt_reg <= '0;
            served_reg   <= '0;
            ped_req_reg  <= 1'b0;
            walk_q_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cool_cnt_reg <= cool_cnt_next;
            served_reg   <= served_next;
            ped_req_reg  <= (state_reg == PENDING);
            walk_q_reg   <= walk_on;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cool_cnt_next = cool_cnt_reg;
        served_next   = served_reg;
        unique case (state_reg)
            // A walk edge coinciding with the press is consumed here, never counted as service.
            IDLE: begin
                if (press) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (walk_rise) begin
                    state_next = SERVING;
                end
            end
            SERVING: begin
                if (walk_fall) begin
                    state_next    = COOLDOWN;
                    cool_cnt_next = '0;
                    if (served_reg != SERVED_MAX) begin
                        served_next = served_reg + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (cool_cnt_reg == COOL_LAST) begin
                    state_next    = IDLE;
                    cool_cnt_next = '0;
                end else begin
                    cool_cnt_next = cool_cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef PED_REQUEST_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

    logic [15:0] blink_cnt_reg;
    logic        wait_led_reg;

    // Phase is restarted whenever ped_req is still low, so the lamp leads with a full lit half-period.
    always_ff @(posedge sys_clkp) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            wait_led_reg  <= 1'b0;
        end else if (state_reg == PENDING) begin
            if (!ped_req_reg) begin
                blink_cnt_reg <= '0;
                wait_led_reg  <= 1'b1;
            end else if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                wait_led_reg  <= ~wait_led_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 16'd1;
            end
        end else begin
            blink_cnt_reg <= '0;
            wait_led_reg  <= 1'b0;
        end
    end

    assign wait_led = wait_led_reg;
`else
    assign wait_led = ped_req_reg;
`endif

    assign ped_req    = ped_req_reg;
    assign served_cnt = served_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request: expectations are queued as stimulus is applied
// and popped for comparison once the DUT has had the corresponding clock edges.
module tb_ped_request;

    localparam int D = 4;
    localparam int C = 6;
    localparam int H = 2;

    logic       sys_clkp = 1'b0;
    logic       reset    = 1'b1;
    logic       button   = 1'b0;
    logic       walk_on  = 1'b0;
    logic       ped_req;
    logic       wait_led;
    logic [7:0] served_cnt;
    logic [1:0] state_o;

    ped_request #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .BLINK_HALF     (H)
    ) dut (
        .sys_clkp  (sys_clkp),
        .reset     (reset),
        .button    (button),
        .walk_on   (walk_on),
        .ped_req   (ped_req),
        .wait_led  (wait_led),
        .served_cnt(served_cnt),
        .state_o   (state_o)
    );

    always #5 sys_clkp = ~sys_clkp;

    typedef struct {
        string      tag;
        logic       ped;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       wled;
        bit         chk_wled;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   exp_served = 0;

    task automatic step(input int n);
        repeat (n) @(negedge sys_clkp);
    endtask

    task automatic push_exp(input string tag, input logic ped, input logic [1:0] st);
        exp_t e;
        e.tag = tag;
        e.ped = ped;
        e.st  = st;
        e.cnt = 8'(exp_served);
`ifdef PED_REQUEST_BLINK_EN
        e.wled     = 1'b0;
        e.chk_wled = !ped;
`else
        e.wled     = ped;
        e.chk_wled = 1'b1;
`endif
        sb.push_back(e);
    endtask

    task automatic push_blink(input string tag, input logic wled);
        exp_t e;
        e.tag      = tag;
        e.ped      = 1'b1;
        e.st       = 2'd1;
        e.cnt      = 8'(exp_served);
        e.wled     = wled;
        e.chk_wled = 1'b1;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (ped_req === e.ped) else begin
            failures++;
            $error("FAIL %s ped_req observed=%b expected=%b", e.tag, ped_req, e.ped);
        end
        checks++;
        assert (state_o === e.st) else begin
            failures++;
            $error("FAIL %s state_o observed=%0d expected=%0d", e.tag, state_o, e.st);
        end
        checks++;
        assert (served_cnt === e.cnt) else begin
            failures++;
            $error("FAIL %s served_cnt observed=%0d expected=%0d", e.tag, served_cnt, e.cnt);
        end
        if (e.chk_wled) begin
            checks++;
            assert (wait_led === e.wled) else begin
                failures++;
                $error("FAIL %s wait_led observed=%b expected=%b", e.tag, wait_led, e.wled);
            end
        end
        $display("step %-16s ped_req=%b state_o=%0d served_cnt=%0d wait_led=%b",
                 e.tag, ped_req, state_o, served_cnt, wait_led);
    endtask

    task automatic expect_after(input string tag, input int n, input logic ped, input logic [1:0] st);
        push_exp(tag, ped, st);
        step(n);
        compare();
    endtask

    initial begin
        logic wexp;

        // Reset state
        expect_after("reset", 3, 1'b0, 2'd0);

        // Held press: first edge sampling high is edge 0, ped_req first high at edge D+4
        reset  = 1'b0;
        button = 1'b1;
        expect_after("lat_edge7", 8, 1'b0, 2'd1);
        for (int i = 0; i < 8; i++) begin
`ifdef PED_REQUEST_BLINK_EN
            wexp = ((i / H) % 2) == 0;
`else
            wexp = 1'b1;
`endif
            push_blink("pending", wexp);
            step(1);
            compare();
        end

        // Walk phase, then cooldown of C cycles
        walk_on = 1'b1;
        expect_after("walk_rise", 1, 1'b1, 2'd2);
        expect_after("ped_drop", 1, 1'b0, 2'd2);
        button = 1'b0;
        expect_after("serving", 8, 1'b0, 2'd2);
        walk_on    = 1'b0;
        exp_served = 1;
        expect_after("cool_enter", 1, 1'b0, 2'd3);
        for (int i = 1; i < C; i++) begin
            expect_after("cooldown", 1, 1'b0, 2'd3);
        end
        expect_after("cool_exit", 1, 1'b0, 2'd0);

        // Bouncing button never settles long enough
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0);
            expect_after("bounce", 2, 1'b0, 2'd0);
        end
        button = 1'b0;
        expect_after("bounce_end", 10, 1'b0, 2'd0);

        // Press and walk rise on the same IDLE cycle: request only, no service
        button = 1'b1;
        step(7);
        walk_on = 1'b1;
        expect_after("sim_press_walk", 1, 1'b0, 2'd1);
        expect_after("sim_no_service", 2, 1'b1, 2'd1);
        walk_on = 1'b0;
        expect_after("sim_walk_low", 1, 1'b1, 2'd1);
        walk_on = 1'b1;
        expect_after("sim_serve", 1, 1'b1, 2'd2);

        // Presses while serving and during cooldown are dropped
        button = 1'b0;
        expect_after("srv_release", 10, 1'b0, 2'd2);
        button = 1'b1;
        expect_after("srv_press", 10, 1'b0, 2'd2);
        button = 1'b0;
        expect_after("srv_release2", 10, 1'b0, 2'd2);
        button = 1'b1;
        step(3);
        walk_on    = 1'b0;
        exp_served = 2;
        expect_after("cool_press", 1, 1'b0, 2'd3);
        expect_after("cool_press_gone", 9, 1'b0, 2'd0);
        button = 1'b0;
        expect_after("idle_release", 10, 1'b0, 2'd0);
        button = 1'b1;
        expect_after("idle_press", 9, 1'b1, 2'd1);
        button  = 1'b0;
        walk_on = 1'b1;
        expect_after("s3_rise", 2, 1'b0, 2'd2);
        walk_on    = 1'b0;
        exp_served = 3;
        expect_after("s3_cool", 1, 1'b0, 2'd3);
        expect_after("s3_idle", 8, 1'b0, 2'd0);

        // Saturation of served_cnt
        for (int n = 0; n < 256; n++) begin
            button = 1'b1;
            step(9);
            button  = 1'b0;
            walk_on = 1'b1;
            step(2);
            walk_on = 1'b0;
            if (exp_served < 255) exp_served++;
            expect_after("sat_loop", 1, 1'b0, 2'd3);
            step(9);
        end
        expect_after("sat_final", 1, 1'b0, 2'd0);

        // Reset while PENDING discards the request on the next edge
        button = 1'b1;
        expect_after("pre_reset_pend", 9, 1'b1, 2'd1);
        reset      = 1'b1;
        exp_served = 0;
        expect_after("reset_pend", 1, 1'b0, 2'd0);
        expect_after("reset_hold", 10, 1'b0, 2'd0);
        button = 1'b0;
        expect_after("reset_hold2", 3, 1'b0, 2'd0);
        reset = 1'b0;
        expect_after("post_reset", 10, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ped_request.md
PED_REQUEST -- requirements
Module: ped_request

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a button level (range 2..65535).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 32, cycles after a walk phase during which presses are ignored (range 1..65535).
REQ-003 SHALL have parameter BLINK_HALF, default 8, half-period in cycles of wait_led blink (range 1..65535).
REQ-004 SHALL have port sys_clkp, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port button, input, 1, raw asynchronous pedestrian push button.
REQ-007 SHALL have port walk_on, input, 1, controller walk light active (light_3 == On decode).
REQ-008 SHALL have port ped_req, output, 1, registered request level to traffic controller push_button input.
REQ-009 SHALL have port wait_led, output, 1, "request pending" indicator.
REQ-010 SHALL have port served_cnt, output, 8, count of completed walk phases.
REQ-011 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-012 SHALL synchronise button through two flops before any other use.
REQ-013 SHALL debounce: btn_db takes the synchronised level once that level has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from 0.
REQ-014 SHALL detect press as btn_db rising edge, single-cycle pulse.
REQ-015 SHALL implement FSM IDLE=0, PENDING=1, SERVING=2, COOLDOWN=3.
REQ-016 IDLE: press -> PENDING; walk_on high without a request is ignored, state stays IDLE.
REQ-017 PENDING: ped_req=1; walk_on rising edge -> SERVING; further presses ignored (no queueing).
REQ-018 SERVING: ped_req=0; walk_on falling edge -> COOLDOWN and served_cnt increments, saturating at 255.
REQ-019 COOLDOWN: counts COOLDOWN_CYCLES cycles then -> IDLE; presses during COOLDOWN are discarded, not latched.
REQ-020 ped_req SHALL be registered and equal 1 exactly while state is PENDING, so it asserts the cycle after entering PENDING.
REQ-021 Latency: with button held stable high, ped_req SHALL assert DEBOUNCE_CYCLES+4 rising edges after the first edge sampling button high.
REQ-022 Press and walk_on rising edge in the same cycle in IDLE SHALL go to PENDING only; that walk_on edge is not treated as service.
REQ-023 walk_on edges SHALL be detected against a registered copy of walk_on.

Reset
REQ-024 Reset SHALL force state IDLE, ped_req=0, wait_led=0, served_cnt=0, btn_db=0, sync flops=0, all counters=0, registered walk_on=0.
REQ-025 Reset asserted mid-operation (any state) SHALL take effect on the next edge and discard any pending request; no press is recognised for the whole reset duration.

Configuration
REQ-026 With PED_REQUEST_BLINK_EN defined, wait_led SHALL toggle every BLINK_HALF cycles while PENDING, starting at 1 on PENDING entry, and be 0 otherwise.
REQ-027 Without PED_REQUEST_BLINK_EN, wait_led SHALL equal ped_req (solid) and the blink counter SHALL not be built.

Structure
REQ-028 FSM state encodings and the served_cnt width constant SHALL reside in shared package traffic_pkg, alongside the light encodings Red/Green/Yellow/On/Off.
REQ-029 Synchroniser plus debouncer SHALL be a sub-module btn_debounce (params DEBOUNCE_CYCLES; ports sys_clkp, reset, din, dout, rise).

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=6, BLINK_HALF=2)
REQ-030 Button high held 20 cycles from cycle 0 -> ped_req=1 first at edge 8, state_o=1.
REQ-031 Button toggling every 2 cycles for 20 cycles then low -> ped_req stays 0, state_o stays 0.
REQ-032 From PENDING, walk_on high 10 cycles then low -> ped_req=0 the cycle after walk_on rises, served_cnt=1 after the fall, state_o=3 for 6 cycles, then 0.
REQ-033 Press during SERVING and during COOLDOWN -> no new PENDING; press after return to IDLE -> PENDING.
REQ-034 256 full request/serve cycles -> served_cnt=255 (saturated); reset asserted while PENDING -> next edge ped_req=0, state_o=0, served_cnt=0.
REQ-035 BLINK_EN defined, 8 cycles in PENDING -> wait_led 1,1,0,0,1,1,0,0; BLINK_EN undefined -> wait_led constantly 1.
